// File: rtl/avg_pkg.sv
// Shared mode encoding and width helpers for the windowed averager.
// Pure declarations: no latency, no backpressure.
package avg_pkg;

    typedef enum logic {
        MODE_BLOCK = 1'b0,
        MODE_SLIDE = 1'b1
    } mode_e;

    // Accumulator width: N samples of DW bits plus a guard bit for the SLIDE subtract.
    function automatic int sum_w(input int dw, input int log2_n);
        return dw + log2_n + 1;
    endfunction

    function automatic int round_bias(input int log2_n, input int rnd);
        return (rnd != 0 && log2_n > 0) ? (1 << (log2_n - 1)) : 0;
    endfunction

endpackage

// File: rtl/avg_window_if.sv
// Sample-stream bundle between a source (master) and the averager (slave).
// No latency of its own; the stream has no backpressure, samples qualify on active.
interface avg_window_if #(
    parameter int DW = 8
);
    logic          active;
    logic [DW-1:0] data_in;
    logic          mode;
    logic          clear;
    logic          done;
    logic [DW-1:0] data_out;

    modport master (
        output active, data_in, mode, clear,
        input  done, data_out
    );

    modport slave (
        input  active, data_in, mode, clear,
        output done, data_out
    );
endinterface

// File: rtl/avg_delay_line.sv
// N-deep circular sample store returning the oldest entry; clr zeroes it (a push alongside lands in slot 0).
// Oldest sample is combinational from the registers; push is always accepted, no backpressure.
module avg_delay_line #(
    parameter int DW     = 8,
    parameter int LOG2_N = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    output logic [DW-1:0] oldest_dat
);
    localparam int N = 1 << LOG2_N;

    logic [DW-1:0]     mem_q [N];
    logic [DW-1:0]     mem_d [N];
    logic [LOG2_N-1:0] ptr_q;
    logic [LOG2_N-1:0] ptr_d;

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        if (clr) begin
            for (int i = 0; i < N; i++) begin
                mem_d[i] = '0;
            end
            ptr_d = '0;
        end
        if (push) begin
            mem_d[ptr_d] = push_dat;
            ptr_d        = ptr_d + LOG2_N'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
        end
    end

    // The write slot is also the oldest entry once the buffer has wrapped.
    assign oldest_dat = mem_q[ptr_q];

endmodule

// File: rtl/avg_window.sv
// Signed power-of-two window averager, BLOCK or SLIDE mode, result with a one-cycle done pulse.
// done/data_out registered one cycle after the qualifying sample; no backpressure, every active sample is taken.
module avg_window
    import avg_pkg::*;
#(
    parameter int DW     = 8,
    parameter int LOG2_N = 2,
    parameter int ROUND  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    avg_window_if.slave bus
);
    localparam int N  = 1 << LOG2_N;
    localparam int SW = sum_w(DW, LOG2_N);
    localparam int CW = LOG2_N + 1;
    localparam logic signed [SW-1:0] BIAS = SW'(round_bias(LOG2_N, ROUND));

    logic [CW-1:0]          count_q, count_d;
    logic signed [SW-1:0]   sum_q, sum_d;
    mode_e                  mode_q, mode_d;
    logic                   done_q, done_d;
    logic signed [DW-1:0]   dout_q, dout_d;

    mode_e                  mode_in;
    logic                   accept;
    logic                   start;
    logic [CW-1:0]          base_cnt;
    logic [CW-1:0]          new_cnt;
    logic signed [SW-1:0]   base_sum;
    logic signed [SW-1:0]   sample_ext;
    logic signed [SW-1:0]   oldest_ext;
    logic signed [SW-1:0]   new_sum;
    logic signed [SW-1:0]   biased;
    logic [DW-1:0]          oldest_dat;

    assign mode_in = mode_e'(bus.mode);
    assign accept  = bus.active & ~bus.clear;
    // An empty window or a mode change opens a fresh window with this sample as sample 1.
    assign start   = (count_q == '0) || (mode_in != mode_q);

    avg_delay_line #(
        .DW     (DW),
        .LOG2_N (LOG2_N)
    ) u_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (bus.clear | (accept & start)),
        .push       (accept & (mode_in == MODE_SLIDE)),
        .push_dat   (bus.data_in),
        .oldest_dat (oldest_dat)
    );

    always_comb begin
        base_cnt   = start ? '0 : count_q;
        base_sum   = start ? '0 : sum_q;
        new_cnt    = base_cnt + CW'(1);
        sample_ext = {{(SW-DW){bus.data_in[DW-1]}}, bus.data_in};
        oldest_ext = '0;
        if (!start && mode_in == MODE_SLIDE) begin
            oldest_ext = {{(SW-DW){oldest_dat[DW-1]}}, oldest_dat};
        end
        new_sum    = base_sum + sample_ext - oldest_ext;
        biased     = new_sum + BIAS;

        count_d = count_q;
        sum_d   = sum_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        dout_d  = dout_q;

        if (bus.clear) begin
            count_d = '0;
            sum_d   = '0;
        end else if (bus.active) begin
            mode_d = mode_in;
            sum_d  = new_sum;
            if (new_cnt == CW'(N)) begin
                done_d = 1'b1;
                dout_d = DW'(biased >>> LOG2_N);
            end
            if (mode_in == MODE_BLOCK) begin
                count_d = (new_cnt == CW'(N)) ? '0 : new_cnt;
                sum_d   = (new_cnt == CW'(N)) ? '0 : new_sum;
            end else begin
                // Saturate at N: a primed SLIDE window stays primed.
                count_d = (base_cnt == CW'(N)) ? base_cnt : new_cnt;
                if (base_cnt == CW'(N)) begin
                    done_d = 1'b1;
                    dout_d = DW'(biased >>> LOG2_N);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            sum_q   <= '0;
            mode_q  <= MODE_BLOCK;
            done_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            count_q <= count_d;
            sum_q   <= sum_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.done     = done_q;
    assign bus.data_out = dout_q;

endmodule

// File: tb/tb_avg_window.sv
// Drives a floor and a rounding averager with identical streams and compares both
// against a queue-based window model every cycle.
module tb_avg_window;

    localparam int DW     = 8;
    localparam int LOG2_N = 2;
    localparam int N      = 1 << LOG2_N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    avg_window_if #(.DW(DW)) bf ();
    avg_window_if #(.DW(DW)) br ();

    avg_window #(.DW(DW), .LOG2_N(LOG2_N), .ROUND(0)) u_floor (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bf.slave)
    );

    avg_window #(.DW(DW), .LOG2_N(LOG2_N), .ROUND(1)) u_round (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (br.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: the samples of the current window, oldest first.
    int win[$];
    bit lmode;
    bit e_done;
    int e_f;
    int e_r;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int floor_div(input int s);
        int q;
        q = s / N;
        if ((s % N) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic int win_sum();
        int s = 0;
        foreach (win[i]) s += win[i];
        return s;
    endfunction

    task automatic model_reset();
        win.delete();
        lmode  = 1'b0;
        e_done = 1'b0;
        e_f    = 0;
        e_r    = 0;
    endtask

    task automatic model_step(input bit act, input int d, input bit m, input bit clr);
        e_done = 1'b0;
        if (clr) begin
            win.delete();
        end else if (act) begin
            if (win.size() == 0 || m != lmode) begin
                win.delete();
                lmode = m;
            end
            win.push_back(d);
            if (m == 1'b1 && win.size() > N) void'(win.pop_front());
            if (win.size() == N) begin
                e_done = 1'b1;
                e_f    = floor_div(win_sum());
                e_r    = floor_div(win_sum() + N / 2);
                if (m == 1'b0) win.delete();
            end
        end
    endtask

    task automatic step(input bit act, input int d, input bit m, input bit clr);
        logic [31:0] dv;
        dv = d;
        bf.active = act; bf.data_in = dv[DW-1:0]; bf.mode = m; bf.clear = clr;
        br.active = act; br.data_in = dv[DW-1:0]; br.mode = m; br.clear = clr;
        @(posedge clk);
        model_step(act, d, m, clr);
        @(negedge clk);
        chk("done_floor", bf.done, e_done);
        chk("dout_floor", $signed(bf.data_out), e_f);
        chk("done_round", br.done, e_done);
        chk("dout_round", $signed(br.data_out), e_r);
    endtask

    task automatic feed(input bit m, input int v);
        step(1'b1, v, m, 1'b0);
    endtask

    task automatic bubble();
        step(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        step(1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        bf.active = 1'b0; bf.data_in = '0; bf.mode = 1'b0; bf.clear = 1'b0;
        br.active = 1'b0; br.data_in = '0; br.mode = 1'b0; br.clear = 1'b0;
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_done", bf.done, 0);
        chk("rst_dout", $signed(bf.data_out), 0);
        rst_n = 1'b1;

        for (int i = 1; i <= 4; i++) feed(1'b0, i);
        chk("blk_1234", $signed(bf.data_out), 2);
        bubble();

        for (int i = 1; i <= 4; i++) feed(1'b0, -i);
        chk("blk_neg_floor", $signed(bf.data_out), -3);
        chk("blk_neg_round", $signed(br.data_out), -2);

        feed(1'b0, 10); bubble(); bubble(); feed(1'b0, 20);
        bubble(); feed(1'b0, 30); feed(1'b0, 40);
        chk("blk_gaps", $signed(bf.data_out), 25);
        bubble();

        for (int i = 1; i <= 6; i++) feed(1'b1, 4 * i);
        chk("slide_ramp", $signed(bf.data_out), 18);

        do_clear();
        for (int i = 0; i < 4; i++) feed(1'b0, 127);
        chk("blk_max", $signed(bf.data_out), 127);
        for (int i = 0; i < 4; i++) feed(1'b0, -128);
        chk("blk_min", $signed(bf.data_out), -128);
        for (int i = 0; i < 6; i++) feed(1'b1, (i % 2 == 0) ? 127 : -128);
        chk("slide_alt", $signed(bf.data_out), -1);

        for (int i = 0; i < 3; i++) feed(1'b0, 7 + i);
        do_clear();
        for (int i = 0; i < 4; i++) feed(1'b0, 100);
        chk("flush_100", $signed(bf.data_out), 100);

        feed(1'b0, 50); feed(1'b0, 60);
        for (int i = 1; i <= 4; i++) feed(1'b1, i * 8);
        chk("mode_flip", $signed(bf.data_out), 20);

        feed(1'b0, 33); feed(1'b0, 44);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_done", bf.done, 0);
        chk("arst_dout", $signed(bf.data_out), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        feed(1'b0, 1); feed(1'b0, 1);

        for (int c = 0; c < 1500; c++) begin
            int v;
            bit act, clr, m;
            act = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 29) == 0);
            m   = ($urandom_range(0, 19) == 0) ? ~bf.mode : bf.mode;
            case ($urandom_range(0, 7))
                0:       v = 127;
                1:       v = -128;
                default: v = int'($urandom_range(0, 255)) - 128;
            endcase
            step(act, v, m, clr);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
